sal_sched: RTL and testbench

SAL_SCHED -- requirements
Module: sal_sched

---
 rtl/sal_sched.sv | 187 ++++++++++++++++++
 tb/tb_sal_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sal_sched.sv
// Per-bank DRAM command scheduler: fixed class priority, round-robin within
// a class, channel timing counters, and a one-cycle registered command output.
module sal_sched #(
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned RA_WIDTH  = 14,
   parameter int unsigned CA_WIDTH  = 10,
   parameter int unsigned T_WIDTH   = 4
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [NUM_BANKS-1:0]                         act_req_i,
   input  logic [NUM_BANKS-1:0]                         rd_req_i,
   input  logic [NUM_BANKS-1:0]                         wr_req_i,
   input  logic [NUM_BANKS-1:0]                         pre_req_i,
   input  logic [NUM_BANKS-1:0]                         ref_req_i,
   input  logic [NUM_BANKS*RA_WIDTH-1:0]                ra_i,
   input  logic [NUM_BANKS*CA_WIDTH-1:0]                ca_i,
   output logic [NUM_BANKS-1:0]                         act_gnt_o,
   output logic [NUM_BANKS-1:0]                         rd_gnt_o,
   output logic [NUM_BANKS-1:0]                         wr_gnt_o,
   output logic [NUM_BANKS-1:0]                         pre_gnt_o,
   output logic [NUM_BANKS-1:0]                         ref_gnt_o,
   input  logic [T_WIDTH-1:0]                           t_rrd_i,
   input  logic [T_WIDTH-1:0]                           t_ccd_i,
   input  logic [T_WIDTH-1:0]                           t_wtr_i,
   input  logic [T_WIDTH-1:0]                           t_rtw_i,
   output logic                                         cmd_valid_o,
   output logic [2:0]                                   cmd_o,
   output logic [$clog2(NUM_BANKS)-1:0]                 cmd_ba_o,
   output logic [((RA_WIDTH > CA_WIDTH) ? RA_WIDTH : CA_WIDTH)-1:0] cmd_addr_o
);

   localparam int unsigned BA_W = $clog2(NUM_BANKS);
   localparam int unsigned AW   = (RA_WIDTH > CA_WIDTH) ? RA_WIDTH : CA_WIDTH;

   localparam logic [2:0] CMD_ACT = 3'd0;
   localparam logic [2:0] CMD_RD  = 3'd1;
   localparam logic [2:0] CMD_WR  = 3'd2;
   localparam logic [2:0] CMD_PRE = 3'd3;
   localparam logic [2:0] CMD_REF = 3'd4;

   // Returns {found, bank}: first requesting bank at or after ptr, wrapping.
   function automatic logic [BA_W:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                             input logic [BA_W-1:0]      ptr);
      logic [BA_W:0] res;
      int            idx;
      res = '0;
      for (int i = int'(NUM_BANKS) - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= int'(NUM_BANKS)) idx = idx - int'(NUM_BANKS);
         if (req[idx]) res = {1'b1, BA_W'(idx)};
      end
      return res;
   endfunction

   // A timing value of 0 behaves like 1.
   function automatic logic [T_WIDTH-1:0] t_load(input logic [T_WIDTH-1:0] t);
      return (t == '0) ? '0 : t - T_WIDTH'(1);
   endfunction

   function automatic logic [T_WIDTH-1:0] t_dec(input logic [T_WIDTH-1:0] c);
      return (c == '0) ? '0 : c - T_WIDTH'(1);
   endfunction

   function automatic logic [BA_W-1:0] ptr_next(input logic [BA_W-1:0] ba);
      return (int'(ba) == int'(NUM_BANKS) - 1) ? '0 : ba + BA_W'(1);
   endfunction

   logic [BA_W-1:0]    act_ptr_q, act_ptr_d, col_ptr_q, col_ptr_d;
   logic [BA_W-1:0]    pre_ptr_q, pre_ptr_d, ref_ptr_q, ref_ptr_d;
   logic [T_WIDTH-1:0] rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d;
   logic               valid_d;
   logic [2:0]         cmd_d;
   logic [BA_W-1:0]    ba_d;
   logic [AW-1:0]      addr_d;

   logic               act_ok, rd_ok, wr_ok;
   logic [NUM_BANKS-1:0] act_el, rd_el, wr_el;
   logic [BA_W:0]      act_pick, col_pick, pre_pick, ref_pick;
   int unsigned        sel;

   assign act_ok = (rrd_q == '0);
   assign rd_ok  = (ccd_q == '0) && (wtr_q == '0);
   assign wr_ok  = (ccd_q == '0) && (rtw_q == '0);
   assign act_el = act_req_i & {NUM_BANKS{act_ok}};
   assign rd_el  = rd_req_i & {NUM_BANKS{rd_ok}};
   assign wr_el  = wr_req_i & {NUM_BANKS{wr_ok}};

   assign ref_pick = rr_pick(ref_req_i, ref_ptr_q);
   assign pre_pick = rr_pick(pre_req_i, pre_ptr_q);
   assign col_pick = rr_pick(rd_el | wr_el, col_ptr_q);
   assign act_pick = rr_pick(act_el, act_ptr_q);

   // Arbitration: highest eligible class wins; grants are gated by reset.
   always_comb begin
      act_gnt_o = '0;
      rd_gnt_o  = '0;
      wr_gnt_o  = '0;
      pre_gnt_o = '0;
      ref_gnt_o = '0;
      valid_d   = 1'b0;
      cmd_d     = '0;
      ba_d      = '0;
      addr_d    = '0;
      act_ptr_d = act_ptr_q;
      col_ptr_d = col_ptr_q;
      pre_ptr_d = pre_ptr_q;
      ref_ptr_d = ref_ptr_q;
      sel       = 0;
      if (rst_n) begin
         if (ref_pick[BA_W]) begin
            ba_d      = ref_pick[BA_W-1:0];
            ref_gnt_o[ba_d] = 1'b1;
            valid_d   = 1'b1;
            cmd_d     = CMD_REF;
            ref_ptr_d = ptr_next(ba_d);
         end else if (pre_pick[BA_W]) begin
            ba_d      = pre_pick[BA_W-1:0];
            pre_gnt_o[ba_d] = 1'b1;
            valid_d   = 1'b1;
            cmd_d     = CMD_PRE;
            pre_ptr_d = ptr_next(ba_d);
         end else if (col_pick[BA_W]) begin
            ba_d      = col_pick[BA_W-1:0];
            sel       = int'(ba_d);
            valid_d   = 1'b1;
            addr_d    = AW'(ca_i[sel*CA_WIDTH +: CA_WIDTH]);
            col_ptr_d = ptr_next(ba_d);
            // Same-bank RD and WR both eligible: read goes first.
            if (rd_el[ba_d]) begin
               rd_gnt_o[ba_d] = 1'b1;
               cmd_d = CMD_RD;
            end else begin
               wr_gnt_o[ba_d] = 1'b1;
               cmd_d = CMD_WR;
            end
         end else if (act_pick[BA_W]) begin
            ba_d      = act_pick[BA_W-1:0];
            sel       = int'(ba_d);
            act_gnt_o[ba_d] = 1'b1;
            valid_d   = 1'b1;
            cmd_d     = CMD_ACT;
            addr_d    = AW'(ra_i[sel*RA_WIDTH +: RA_WIDTH]);
            act_ptr_d = ptr_next(ba_d);
         end
      end
   end

   // Timing counters: reload on their trigger grant, else count down to 0.
   always_comb begin
      rrd_d = (|act_gnt_o) ? t_load(t_rrd_i) : t_dec(rrd_q);
      ccd_d = (|rd_gnt_o || |wr_gnt_o) ? t_load(t_ccd_i) : t_dec(ccd_q);
      wtr_d = (|wr_gnt_o) ? t_load(t_wtr_i) : t_dec(wtr_q);
      rtw_d = (|rd_gnt_o) ? t_load(t_rtw_i) : t_dec(rtw_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         act_ptr_q   <= '0;
         col_ptr_q   <= '0;
         pre_ptr_q   <= '0;
         ref_ptr_q   <= '0;
         rrd_q       <= '0;
         ccd_q       <= '0;
         wtr_q       <= '0;
         rtw_q       <= '0;
         cmd_valid_o <= 1'b0;
         cmd_o       <= '0;
         cmd_ba_o    <= '0;
         cmd_addr_o  <= '0;
      end else begin
         act_ptr_q   <= act_ptr_d;
         col_ptr_q   <= col_ptr_d;
         pre_ptr_q   <= pre_ptr_d;
         ref_ptr_q   <= ref_ptr_d;
         rrd_q       <= rrd_d;
         ccd_q       <= ccd_d;
         wtr_q       <= wtr_d;
         rtw_q       <= rtw_d;
         cmd_valid_o <= valid_d;
         cmd_o       <= cmd_d;
         cmd_ba_o    <= ba_d;
         cmd_addr_o  <= addr_d;
      end
   end

endmodule

// File: tb/tb_sal_sched.sv
// Directed bench for sal_sched: grants checked in-cycle, registered command
// checked one cycle later against a scoreboard queue.
module tb_sal_sched;

   localparam int unsigned NB = 4;
   localparam int unsigned RW = 14;
   localparam int unsigned CW = 10;
   localparam int unsigned TW = 4;
   localparam int unsigned AW = 14;

   typedef struct packed {
      logic [2:0]    cmd;
      logic [1:0]    ba;
      logic [AW-1:0] addr;
   } cmd_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NB-1:0]     act_req, rd_req, wr_req, pre_req, ref_req;
   logic [NB*RW-1:0]  ra;
   logic [NB*CW-1:0]  ca;
   logic [NB-1:0]     act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
   logic [TW-1:0]     t_rrd, t_ccd, t_wtr, t_rtw;
   logic              cmd_valid;
   logic [2:0]        cmd;
   logic [1:0]        cmd_ba;
   logic [AW-1:0]     cmd_addr;

   int   checks = 0;
   int   errors = 0;
   cmd_t sb_q[$];

   always #5 clk = ~clk;

   sal_sched #(.NUM_BANKS(NB), .RA_WIDTH(RW), .CA_WIDTH(CW), .T_WIDTH(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
      .pre_req_i(pre_req), .ref_req_i(ref_req),
      .ra_i(ra), .ca_i(ca),
      .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
      .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
      .t_rrd_i(t_rrd), .t_ccd_i(t_ccd), .t_wtr_i(t_wtr), .t_rtw_i(t_rtw),
      .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba), .cmd_addr_o(cmd_addr)
   );

   function automatic logic [RW-1:0] ra_of(input int b);
      return RW'(14'h1A50 + b);
   endfunction

   function automatic logic [CW-1:0] ca_of(input int b);
      return CW'(10'h2C0 + b);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: check grants now, then the registered command after the edge.
   task automatic tick(input string tag, input logic v, input logic [2:0] c, input int b);
      logic [NB-1:0] one;
      cmd_t          e;
      cmd_t          got;
      one = v ? NB'(1 << b) : '0;
      #1;
      chk({tag, ":act_gnt"}, 32'(act_gnt), (v && c == 3'd0) ? 32'(one) : 32'd0);
      chk({tag, ":rd_gnt"},  32'(rd_gnt),  (v && c == 3'd1) ? 32'(one) : 32'd0);
      chk({tag, ":wr_gnt"},  32'(wr_gnt),  (v && c == 3'd2) ? 32'(one) : 32'd0);
      chk({tag, ":pre_gnt"}, 32'(pre_gnt), (v && c == 3'd3) ? 32'(one) : 32'd0);
      chk({tag, ":ref_gnt"}, 32'(ref_gnt), (v && c == 3'd4) ? 32'(one) : 32'd0);
      if (v) begin
         e.cmd  = c;
         e.ba   = 2'(b);
         e.addr = (c == 3'd0) ? AW'(ra_of(b)) :
                  (c == 3'd1 || c == 3'd2) ? AW'(ca_of(b)) : '0;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      got = '{cmd: cmd, ba: cmd_ba, addr: cmd_addr};
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, ":cmd_valid"}, 32'(cmd_valid), 32'd1);
         chk({tag, ":cmd_fields"}, 32'(got), 32'(e));
      end else begin
         chk({tag, ":cmd_valid"}, 32'(cmd_valid), 32'd0);
         chk({tag, ":cmd_fields"}, 32'(got), 32'd0);
      end
      @(negedge clk);
   endtask

   task automatic clr();
      act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      clr();
      for (int b = 0; b < int'(NB); b++) begin
         ra[b*RW +: RW] = ra_of(b);
         ca[b*CW +: CW] = ca_of(b);
      end
      t_rrd = 4'd1; t_ccd = 4'd1; t_wtr = 4'd1; t_rtw = 4'd1;

      // Reset with requests present: no grants, outputs cleared.
      act_req = 4'b1111;
      tick("rst0", 1'b0, 3'd0, 0);
      tick("rst1", 1'b0, 3'd0, 0);
      rst_n = 1'b1;

      // ACT round robin spaced by tRRD = 3.
      t_rrd = 4'd3;
      for (int c = 0; c < 10; c++) begin
         if (c % 3 == 0) tick("act_rrd", 1'b1, 3'd0, c / 3);
         else            tick("act_rrd", 1'b0, 3'd0, 0);
      end
      clr();
      for (int c = 0; c < 3; c++) tick("idle_a", 1'b0, 3'd0, 0);

      // Priority: REF > PRE > RD > ACT across different banks.
      rd_req[1] = 1'b1; pre_req[2] = 1'b1; act_req[3] = 1'b1; ref_req[0] = 1'b1;
      tick("prio_ref", 1'b1, 3'd4, 0);
      ref_req = '0;
      tick("prio_pre", 1'b1, 3'd3, 2);
      pre_req = '0;
      tick("prio_rd", 1'b1, 3'd1, 1);
      rd_req = '0;
      tick("prio_act", 1'b1, 3'd0, 3);
      clr();
      for (int c = 0; c < 3; c++) tick("idle_b", 1'b0, 3'd0, 0);

      // Write-to-read turnaround: tWTR = 4, tCCD = 2.
      t_wtr = 4'd4; t_ccd = 4'd2;
      wr_req[0] = 1'b1;
      tick("wtr_wr", 1'b1, 3'd2, 0);
      wr_req = '0; rd_req[1] = 1'b1;
      for (int c = 1; c < 4; c++) tick("wtr_wait", 1'b0, 3'd0, 0);
      tick("wtr_rd", 1'b1, 3'd1, 1);

      // Column class blocked by tCCD must not block an eligible ACT.
      rd_req = 4'b0100; act_req[0] = 1'b1;
      tick("blk_act", 1'b1, 3'd0, 0);
      act_req = '0;
      tick("blk_rd", 1'b1, 3'd1, 2);
      clr();
      tick("idle_c", 1'b0, 3'd0, 0);

      // Reset right after an ACT with tRRD = 8 drops pending timing.
      t_rrd = 4'd8; t_ccd = 4'd1;
      act_req[1] = 1'b1;
      tick("rr_act", 1'b1, 3'd0, 1);
      rst_n = 1'b0; act_req = 4'b1111;
      tick("rr_rst", 1'b0, 3'd0, 0);
      rst_n = 1'b1; act_req = 4'b0100;
      tick("rr_after", 1'b1, 3'd0, 2);
      clr();

      // Back-to-back reads with tCCD = 1 wrap around the banks.
      rd_req = 4'b1111;
      for (int c = 0; c < 5; c++) tick("rd_wrap", 1'b1, 3'd1, c % 4);

      // tCCD = 0 behaves as 1: still one read per cycle.
      t_ccd = 4'd0;
      tick("ccd_zero", 1'b1, 3'd1, 1);
      tick("ccd_zero", 1'b1, 3'd1, 2);
      clr();
      tick("idle_d", 1'b0, 3'd0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
